// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier: default widths and
// the controller state encoding used by the control FSM, datapath and benches.
package mul_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int PWIDTH_DEF = 32;

    typedef enum logic [2:0] {
        S0_IDLE   = 3'd0,
        S1_LOAD_A = 3'd1,
        S2_LOAD_B = 3'd2,
        S3_ACCUM  = 3'd3,
        S4_DONE   = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/mul_out_reg.sv
// Output holding register with valid/ready handshake. A capture pulse arriving
// while a result is still unconsumed is dropped and flagged in a sticky overrun.
module mul_out_reg
    import mul_pkg::*;
#(
    parameter int DW = PWIDTH_DEF + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          capture_i,
    input  logic [DW-1:0] data_i,
    input  logic          out_ready_i,
    output logic [DW-1:0] data_o,
    output logic          out_valid_o,
    output logic          overrun_o
);

    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (capture_i) begin
            // A slot frees up in the same cycle the consumer takes the old value.
            if (!valid_q || out_ready_i) begin
                data_d  = data_i;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o      = data_q;
    assign out_valid_o = valid_q;
    assign overrun_o   = overrun_q;

endmodule

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: operand A, down-counter B, accumulator P
// and a handshaked product register. Define MUL_OVF_SAT_EN to saturate P on overflow.
module mul_datapath
    import mul_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int PWIDTH = PWIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              ldA,
    input  logic              ldB,
    input  logic              ldP,
    input  logic              clrP,
    input  logic              decB,
    input  logic              add,
    input  logic              done,
    output logic              zero,
    output logic [PWIDTH-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ovf,
    output logic              ovf_out,
    output logic              overrun,
    output logic              proto_err
);

    localparam int DW = PWIDTH + 1;

    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [PWIDTH-1:0] p_q, p_d;
    logic              ovf_q, ovf_d;
    logic              proto_err_q, proto_err_d;
    logic              done_q;
    logic [PWIDTH:0]   sum;
    logic              accum;
    logic              capture;
    logic [DW-1:0]     out_data;

    assign zero  = (b_q == '0);
    assign accum = add | ldP;
    // One extra bit so the carry-out of P + A is visible.
    assign sum   = {1'b0, p_q} + {{(PWIDTH + 1 - WIDTH){1'b0}}, a_q};

    always_comb begin
        a_d         = ldA ? data_in : a_q;
        b_d         = b_q;
        proto_err_d = proto_err_q;
        if (ldB) begin
            b_d = data_in;
        end else if (decB) begin
            if (zero) begin
                proto_err_d = 1'b1;
            end else begin
                b_d = b_q - WIDTH'(1);
            end
        end

        p_d   = p_q;
        ovf_d = ovf_q;
        if (clrP) begin
            p_d   = '0;
            ovf_d = 1'b0;
        end else if (accum) begin
            if (sum[PWIDTH]) begin
                ovf_d = 1'b1;
            end
`ifdef MUL_OVF_SAT_EN
            p_d = (ovf_q || sum[PWIDTH]) ? '1 : sum[PWIDTH-1:0];
`else
            p_d = sum[PWIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
            proto_err_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            ovf_q       <= ovf_d;
            proto_err_q <= proto_err_d;
            done_q      <= done;
        end
    end

    // done is a held level, so only its rising edge marks a completed operation.
    assign capture = done & ~done_q;

    mul_out_reg #(
        .DW(DW)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .capture_i  (capture),
        .data_i     ({ovf_q, p_q}),
        .out_ready_i(out_ready),
        .data_o     (out_data),
        .out_valid_o(out_valid),
        .overrun_o  (overrun)
    );

    assign product   = out_data[PWIDTH-1:0];
    assign ovf_out   = out_data[PWIDTH];
    assign ovf       = ovf_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mul_datapath.sv
// Self-checking bench for mul_datapath: a 16x32 and a 16x16 instance driven by the
// same strobes, checked against an arithmetic model of the product and overflow.
module tb_mul_datapath;
    import mul_pkg::*;

    localparam int W    = 16;
    localparam int PW   = 32;
    localparam int PW16 = 16;
`ifdef MUL_OVF_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [W-1:0]    data_in;
    logic            ldA, ldB, ldP, clrP, decB, add, done, out_ready;

    logic            zero, out_valid, ovf, ovf_out, overrun, proto_err;
    logic [PW-1:0]   product;
    logic            zero16, out_valid16, ovf16, ovf_out16, overrun16, proto_err16;
    logic [PW16-1:0] product16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_datapath #(.WIDTH(W), .PWIDTH(PW)) dut (
        .clk(clk), .reset(reset), .data_in(data_in),
        .ldA(ldA), .ldB(ldB), .ldP(ldP), .clrP(clrP), .decB(decB), .add(add), .done(done),
        .zero(zero), .product(product), .out_valid(out_valid), .out_ready(out_ready),
        .ovf(ovf), .ovf_out(ovf_out), .overrun(overrun), .proto_err(proto_err)
    );

    mul_datapath #(.WIDTH(W), .PWIDTH(PW16)) dut16 (
        .clk(clk), .reset(reset), .data_in(data_in),
        .ldA(ldA), .ldB(ldB), .ldP(ldP), .clrP(clrP), .decB(decB), .add(add), .done(done),
        .zero(zero16), .product(product16), .out_valid(out_valid16), .out_ready(out_ready),
        .ovf(ovf16), .ovf_out(ovf_out16), .overrun(overrun16), .proto_err(proto_err16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Product a*b reduced to pw bits, either wrapped or saturated.
    function automatic logic [63:0] model_prod(input logic [63:0] full, input int pw);
        logic [63:0] lim;
        lim = 64'd1 << pw;
        if (full < lim) return full;
        return SAT ? (lim - 64'd1) : (full & (lim - 64'd1));
    endfunction

    function automatic logic model_ovf(input logic [63:0] full, input int pw);
        return full >= (64'd1 << pw);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes_off();
        ldA = 0; ldB = 0; ldP = 0; clrP = 0; decB = 0; add = 0;
    endtask

    // Controller-like sequence up to and including the first cycle with done high.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit use_ldp,
                            input bit load_a);
        int n;
        if (load_a) begin
            data_in = a; ldA = 1; cyc(); ldA = 0;
        end
        data_in = b; ldB = 1; clrP = 1; cyc(); ldB = 0; clrP = 0;
        check("zero_after_ldB", {63'd0, zero}, {63'd0, b == '0});
        n = 0;
        while (!zero && n < 1000) begin
            ldP = use_ldp; add = !use_ldp; decB = 1;
            cyc();
            n++;
        end
        strobes_off();
        check("iters", 64'(n), 64'(b));
        done = 1;
        cyc();
        $display("op a=%0d b=%0d -> product=%0d ovf_out=%0b product16=0x%0h ovf_out16=%0b valid=%0b overrun=%0b",
                 a, b, product, ovf_out, product16, ovf_out16, out_valid, overrun);
    endtask

    task automatic end_op();
        cyc();
        done = 0;
        cyc();
    endtask

    task automatic check_result(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] full;
        full = 64'(a) * 64'(b);
        check("product32", 64'(product), model_prod(full, PW));
        check("ovf_out32", {63'd0, ovf_out}, {63'd0, model_ovf(full, PW)});
        check("product16", 64'(product16), model_prod(full, PW16));
        check("ovf_out16", {63'd0, ovf_out16}, {63'd0, model_ovf(full, PW16)});
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        reset = 1; done = 0; out_ready = 1; data_in = '0;
        strobes_off();
        cyc(); cyc();
        reset = 0;
        cyc();
        check("rst_zero", {63'd0, zero}, 64'd1);
        check("rst_product", 64'(product), 64'd0);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_flags", {60'd0, ovf, ovf_out, overrun, proto_err}, 64'd0);

        // 7 x 5 with the consumer ready: one-cycle valid pulse.
        start_op(16'd7, 16'd5, 1'b0, 1'b1);
        check("v_7x5", {63'd0, out_valid}, 64'd1);
        check_result(16'd7, 16'd5);
        cyc();
        check("v_drop_7x5", {63'd0, out_valid}, 64'd0);
        done = 0; cyc();

        // B = 0: no accumulation at all.
        start_op(16'd9, 16'd0, 1'b0, 1'b1);
        check("v_b0", {63'd0, out_valid}, 64'd1);
        check_result(16'd9, 16'd0);
        end_op();

        // Overflow on the narrow instance.
        start_op(16'hFFFF, 16'd3, 1'b0, 1'b1);
        check("ovf16_live", {63'd0, ovf16}, 64'd1);
        check("ovf32_live", {63'd0, ovf}, 64'd0);
        check("sat_or_wrap16", 64'(product16), SAT ? 64'hFFFF : 64'hFFFD);
        check_result(16'hFFFF, 16'd3);
        end_op();

        // Stalled consumer: second result dropped, overrun set.
        out_ready = 0;
        start_op(16'd7, 16'd5, 1'b1, 1'b1);
        check("stall_first", 64'(product), 64'd35);
        end_op();
        check("stall_hold_valid", {63'd0, out_valid}, 64'd1);
        check("no_overrun_yet", {63'd0, overrun}, 64'd0);
        start_op(16'd3, 16'd4, 1'b0, 1'b1);
        check("stall_kept", 64'(product), 64'd35);
        check("overrun", {63'd0, overrun}, 64'd1);
        check("overrun16", {63'd0, overrun16}, 64'd1);
        end_op();
        out_ready = 1;
        cyc();
        check("drain_valid", {63'd0, out_valid}, 64'd0);
        check("drain_product", 64'(product), 64'd35);

        // decB at B == 0.
        check("no_proto_err", {63'd0, proto_err}, 64'd0);
        decB = 1; cyc(); decB = 0;
        check("decB0_zero", {63'd0, zero}, 64'd1);
        check("proto_err", {63'd0, proto_err}, 64'd1);
        check("proto_err16", {63'd0, proto_err16}, 64'd1);

        // clrP beats a concurrent add.
        data_in = 16'd5; ldA = 1; cyc(); ldA = 0;
        add = 1; cyc();
        clrP = 1; cyc();
        strobes_off();
        done = 1; cyc();
        $display("op clrP+add -> product=%0d valid=%0b", product, out_valid);
        check("clrp_prio", 64'(product), 64'd0);
        check("clrp_valid", {63'd0, out_valid}, 64'd1);
        end_op();

        // Randomised operations, alternating add and ldP as the accumulate strobe.
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom_range(0, 200));
            start_op(ra, rb, i[0], 1'b1);
            check("rnd_valid", {63'd0, out_valid}, 64'd1);
            check_result(ra, rb);
            end_op();
        end
        check("sticky_overrun", {63'd0, overrun}, 64'd1);
        check("sticky_proto", {63'd0, proto_err}, 64'd1);

        // Asynchronous reset in the middle of an accumulation.
        start_op(16'd7, 16'd5, 1'b0, 1'b1);
        end_op();
        data_in = 16'd9; ldA = 1; cyc(); ldA = 0;
        data_in = 16'd3; ldB = 1; clrP = 1; cyc(); ldB = 0; clrP = 0;
        add = 1; decB = 1; cyc();
        #2 reset = 1;
        #1;
        check("arst_product", 64'(product), 64'd0);
        check("arst_valid", {63'd0, out_valid}, 64'd0);
        check("arst_flags", {60'd0, ovf, ovf_out, overrun, proto_err}, 64'd0);
        check("arst_zero", {63'd0, zero}, 64'd1);
        strobes_off();
        cyc();
        reset = 0;
        cyc();
        start_op(16'd0, 16'd2, 1'b0, 1'b0);
        check("post_rst_product", 64'(product), 64'd0);
        check("post_rst_ovf", {63'd0, ovf_out}, 64'd0);
        end_op();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_datapath.md
Name: mul_datapath

Overview:
- Datapath for the repeated-addition multiplier. It consumes the strobes from the multiplier control FSM (ldA, ldB, ldP, clrP, decB, add, done) and returns the zero status to that FSM.
- Holds operand A, down-counter B and accumulator P.
- On each completion, captures the product into an output holding register. The downstream consumer reads it through a valid/ready handshake.

Parameters:
- WIDTH, 16, width of operands A and B and of data_in.
- PWIDTH, 32, width of accumulator P and of product output; legal range WIDTH..2*WIDTH.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  shared operand bus, sampled on ldA/ldB.
- ldA  input  1  load A from data_in.
- ldB  input  1  load B from data_in.
- ldP  input  1  accumulate strobe (alias of add).
- clrP  input  1  clear P and clear ovf.
- decB  input  1  decrement B.
- add  input  1  P <= P + A.
- done  input  1  level from controller, held high while finished.
- zero  output  1  combinational, high when B == 0.
- product  output  PWIDTH  captured product.
- out_valid  output  1  product holds an unconsumed result.
- out_ready  input  1  downstream accepts product.
- ovf  output  1  sticky accumulator-overflow flag for current operation.
- ovf_out  output  1  ovf value captured alongside product.
- overrun  output  1  sticky: a result was lost because the output register was full.
- proto_err  output  1  sticky: decB issued while B == 0.

Behaviour:
- Reset (asynchronous) clears everything: A=0, B=0, P=0, ovf=0, done_q=0, product=0, out_valid=0, ovf_out=0, overrun=0, proto_err=0.
- zero is purely combinational from the B register, so it is 1 after reset. Reset asserted mid-operation aborts that operation immediately with no output capture.
- Register updates take effect on the next clock edge, with one cycle latency from strobe to register.
- ldA: A <= data_in.
- ldB: B <= data_in. If ldA and ldB are both high, both registers load the same data_in.
- ldB and decB in the same cycle: ldB wins.
- decB with B != 0: B <= B - 1.
- decB with B == 0: B holds at 0 (no wrap) and proto_err is set.
- Accumulate when (add | ldP): sum = P + zero-extended A, computed at PWIDTH+1 bits. If the carry-out bit is set, ovf <= 1. P is then updated per the OVF_SAT_EN rule.
- clrP has priority over accumulate: P <= 0 and ovf <= 0, and any concurrent add/ldP is ignored.
- Completion is detected on the rising edge of done (done_q tracks done). Because done is a level held in the finished state, exactly one capture happens per operation.
- Capture when out_valid == 0, or when out_valid == 1 and out_ready == 1 in the same cycle: product <= P, ovf_out <= ovf, out_valid <= 1.
- Capture when out_valid == 1 and out_ready == 0: the held product is kept, the new result is dropped, and overrun is set.
- Handshake without capture: out_valid && out_ready clears out_valid, and product holds its last value.
- proto_err and overrun clear only on reset.
- Expected control sequence: ldA, then ldB+clrP, then add+decB repeated while zero == 0, then done. With B = 0 loaded, the product is 0 and no accumulate occurs.

Optional Feature:
- Macro: MUL_OVF_SAT_EN.
- Defined: on overflow P saturates to all-ones and stays there for the rest of the operation. Later adds keep it saturated until clrP.
- Undefined: P wraps modulo 2^PWIDTH.
- ovf is set identically in both builds.

Decomposition:
- Shared package mul_pkg holds the WIDTH/PWIDTH defaults and the controller state encoding S0..S4 (IDLE, LOAD_A, LOAD_B, ACCUM, DONE), shared with the control FSM and benches.
- One sub-module, mul_out_reg: the output holding register with valid/ready, capture pulse input and overrun flag, parameterised on data width (PWIDTH+1 to carry ovf_out).

Test Plan:
- A=7, B=5 via the full strobe sequence, out_ready=1 -> zero rises after 5 add/decB cycles; one capture with product=35, ovf_out=0, out_valid for one cycle.
- B=0 loaded -> zero=1 immediately; on done, product=0 with no accumulate.
- WIDTH=16, PWIDTH=16, A=0xFFFF, B=3 -> ovf=1, ovf_out=1; product=0xFFFF with MUL_OVF_SAT_EN defined, 0xFFFD without.
- out_ready=0 after first result (product=35), second run gives 12 -> product stays 35, overrun=1; raise out_ready -> out_valid drops.
- decB while B==0 -> B stays 0, proto_err=1. clrP+add same cycle -> P=0.
- Reset asserted mid-ACCUM with B=3 -> all outputs 0 asynchronously; zero=1; no capture when done later rises after a fresh run without ldA.
